timer_periph: RTL and testbench



---
 rtl/timer_periph.sv | 123 ++++++++++++
 tb/tb_timer_periph.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_periph.sv
// Memory-mapped timer / LED / switch / systick peripheral at 0x4000_00xx.
// Define TIMER_PRESCALE_EN to add the PRESCALE register and tick down-counter.
module timer_periph (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    input  logic [7:0]  switch,
    output logic [7:0]  led,
    output logic        IRQ
);
    localparam logic [23:0] BASE_HI  = 24'h40_0000;
    localparam logic [5:0]  IDX_TH   = 6'd0;
    localparam logic [5:0]  IDX_TL   = 6'd1;
    localparam logic [5:0]  IDX_TCON = 6'd2;
    localparam logic [5:0]  IDX_LED  = 6'd3;
    localparam logic [5:0]  IDX_SW   = 6'd4;
    localparam logic [5:0]  IDX_SYS  = 6'd5;
    localparam logic [5:0]  IDX_PS   = 6'd6;

    logic [31:0] th;
    logic [31:0] tl;
    logic [31:0] sysTick;
    logic [2:0]  tcon;
    logic [7:0]  ledReg;
    logic        inWindow;
    logic [5:0]  wordIdx;
    logic        wrTh;
    logic        wrTl;
    logic        wrTcon;
    logic        wrLed;
    logic        tick;
    logic        countEn;
    logic        overflow;
    logic        setStatus;
    logic        unusedAddrBits;

    assign unusedAddrBits = ^Addr[1:0];
    assign inWindow = (Addr[31:8] == BASE_HI);
    assign wordIdx  = Addr[7:2];
    assign wrTh     = MemWrite && inWindow && (wordIdx == IDX_TH);
    assign wrTl     = MemWrite && inWindow && (wordIdx == IDX_TL);
    assign wrTcon   = MemWrite && inWindow && (wordIdx == IDX_TCON);
    assign wrLed    = MemWrite && inWindow && (wordIdx == IDX_LED);

    // A bus write to TL pre-empts the count, so it also suppresses the status set.
    assign countEn   = tick && tcon[0];
    assign overflow  = countEn && (tl == 32'hFFFF_FFFF);
    assign setStatus = overflow && tcon[1] && !wrTl;

`ifdef TIMER_PRESCALE_EN
    logic [15:0] prescale;
    logic [15:0] psCnt;
    logic        wrPs;

    assign wrPs = MemWrite && inWindow && (wordIdx == IDX_PS);
    assign tick = (psCnt == 16'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescale <= 16'd0;
            psCnt    <= 16'd0;
        end else if (wrPs) begin
            prescale <= WriteData[15:0];
            psCnt    <= WriteData[15:0];
        end else if (tcon[0]) begin
            psCnt <= (psCnt == 16'd0) ? prescale : psCnt - 16'd1;
        end
    end
`else
    assign tick = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th      <= 32'd0;
            tl      <= 32'd0;
            tcon    <= 3'd0;
            ledReg  <= 8'd0;
            sysTick <= 32'd0;
        end else begin
            sysTick <= sysTick + 32'd1;
            if (wrTh)
                th <= WriteData;
            if (wrTl)
                tl <= WriteData;
            else if (countEn)
                tl <= overflow ? th : tl + 32'd1;
            // Hardware status set wins over a simultaneous software clear.
            if (wrTcon)
                tcon <= {WriteData[2] | setStatus, WriteData[1:0]};
            else if (setStatus)
                tcon[2] <= 1'b1;
            if (wrLed)
                ledReg <= WriteData[7:0];
        end
    end

    always_comb begin
        ReadData = 32'd0;
        if (MemRead && inWindow) begin
            case (wordIdx)
                IDX_TH:   ReadData = th;
                IDX_TL:   ReadData = tl;
                IDX_TCON: ReadData = {29'd0, tcon};
                IDX_LED:  ReadData = {24'd0, ledReg};
                IDX_SW:   ReadData = {24'd0, switch};
                IDX_SYS:  ReadData = sysTick;
`ifdef TIMER_PRESCALE_EN
                IDX_PS:   ReadData = {16'd0, prescale};
`endif
                default:  ReadData = 32'd0;
            endcase
        end
    end

    assign led = ledReg;
    assign IRQ = tcon[2];

endmodule

// File: tb/tb_timer_periph.sv
// Self-checking bench for timer_periph: directed literal checks plus randomized
// bus traffic compared every cycle against a register-level behavioural model.
module tb_timer_periph;
    localparam logic [31:0] A_TH   = 32'h4000_0000;
    localparam logic [31:0] A_TL   = 32'h4000_0004;
    localparam logic [31:0] A_TCON = 32'h4000_0008;
    localparam logic [31:0] A_LED  = 32'h4000_000C;
    localparam logic [31:0] A_SW   = 32'h4000_0010;
    localparam logic [31:0] A_SYS  = 32'h4000_0014;
    localparam logic [31:0] A_PS   = 32'h4000_0018;
`ifdef TIMER_PRESCALE_EN
    localparam int NREG = 7;
`else
    localparam int NREG = 6;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Addr;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [7:0]  switch;
    logic [7:0]  led;
    logic        IRQ;
    int          checks = 0;
    int          errors = 0;

    timer_periph dut (
        .clk(clk), .reset(reset), .Addr(Addr), .MemRead(MemRead),
        .MemWrite(MemWrite), .WriteData(WriteData), .ReadData(ReadData),
        .switch(switch), .led(led), .IRQ(IRQ)
    );

    always #5 clk = ~clk;

    // Behavioural model: register file state plus per-cycle update rules.
    logic [31:0] mTh, mTl, mSys;
    logic [2:0]  mTcon;
    logic [7:0]  mLed;
    logic [5:0]  wIdx;
    logic        wHit, mTick, mRun, mOvf, mSet;
`ifdef TIMER_PRESCALE_EN
    logic [15:0] mPre, mPs;
`endif

    always_comb begin
        wIdx = Addr[7:2];
        wHit = MemWrite && (Addr[31:8] == 24'h40_0000) && (int'(wIdx) < NREG);
`ifdef TIMER_PRESCALE_EN
        mTick = (mPs == 16'd0);
`else
        mTick = 1'b1;
`endif
        mRun = mTick && mTcon[0];
        mOvf = mRun && (mTl == 32'hFFFF_FFFF);
        mSet = mOvf && mTcon[1] && !(wHit && wIdx == 6'd1);
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mTh <= 0; mTl <= 0; mSys <= 0; mTcon <= 0; mLed <= 0;
`ifdef TIMER_PRESCALE_EN
            mPre <= 0; mPs <= 0;
`endif
        end else begin
            mSys <= mSys + 32'd1;
            if (wHit && wIdx == 6'd0) mTh <= WriteData;
            if (wHit && wIdx == 6'd1) mTl <= WriteData;
            else if (mRun) mTl <= mOvf ? mTh : mTl + 32'd1;
            if (wHit && wIdx == 6'd2) mTcon <= {WriteData[2] | mSet, WriteData[1:0]};
            else if (mSet) mTcon[2] <= 1'b1;
            if (wHit && wIdx == 6'd3) mLed <= WriteData[7:0];
`ifdef TIMER_PRESCALE_EN
            if (wHit && wIdx == 6'd6) begin
                mPre <= WriteData[15:0];
                mPs  <= WriteData[15:0];
            end else if (mTcon[0]) begin
                mPs <= (mPs == 16'd0) ? mPre : mPs - 16'd1;
            end
`endif
        end
    end

    function automatic logic [31:0] expRead();
        logic [31:0] r;
        r = 32'd0;
        if (MemRead && Addr[31:8] == 24'h40_0000) begin
            case (Addr[7:2])
                6'd0: r = mTh;
                6'd1: r = mTl;
                6'd2: r = {29'd0, mTcon};
                6'd3: r = {24'd0, mLed};
                6'd4: r = {24'd0, switch};
                6'd5: r = mSys;
`ifdef TIMER_PRESCALE_EN
                6'd6: r = {16'd0, mPre};
`endif
                default: r = 32'd0;
            endcase
        end
        return r;
    endfunction

    initial forever begin
        @(negedge clk);
        checks++;
        if (ReadData !== expRead()) begin
            errors++;
            $display("FAIL readData t=%0t addr=%h got %h expected %h", $time, Addr, ReadData, expRead());
        end
        checks++;
        if (led !== mLed) begin
            errors++;
            $display("FAIL led t=%0t got %h expected %h", $time, led, mLed);
        end
        checks++;
        if (IRQ !== mTcon[2]) begin
            errors++;
            $display("FAIL irq t=%0t got %b expected %b", $time, IRQ, mTcon[2]);
        end
    end

    task automatic checkVal(input logic [31:0] act, input logic [31:0] exp, input string name);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkRead(input logic [31:0] a, input logic [31:0] exp, input string name);
        Addr = a; MemRead = 1'b1; MemWrite = 1'b0;
        #2;
        checkVal(ReadData, exp, name);
        MemRead = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        Addr = a; WriteData = d; MemWrite = 1'b1; MemRead = 1'b0;
        @(posedge clk); #1;
        MemWrite = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] s0;
        logic [5:0]  ri;
        reset = 1'b0; Addr = 0; MemRead = 0; MemWrite = 0; WriteData = 0; switch = 8'h00;
        idle(2);
        checkVal(32'(IRQ), 0, "irq_in_reset");
        checkRead(A_TCON, 0, "tcon_in_reset");
        @(posedge clk); #1;
        reset = 1'b1;

        // Reset in the middle of counting.
        wr(A_LED, 32'hA5);
        wr(A_TH, 0);
        wr(A_TL, 32'h1234);
        wr(A_TCON, 7);
        checkVal(32'(IRQ), 1, "irq_sw_set");
        checkRead(A_TL, 32'h1234, "tl_before_count");
        idle(3);
        checkRead(A_TL, 32'h1237, "tl_counting");
        reset = 1'b0;
        #1;
        checkVal(32'(IRQ), 0, "irq_async_reset");
        checkVal(32'(led), 0, "led_async_reset");
        checkRead(A_TL, 0, "tl_reset");
        checkRead(A_TCON, 0, "tcon_reset");
        checkRead(A_LED, 0, "led_reg_reset");
        checkRead(A_SYS, 0, "systick_reset");
        @(posedge clk); #1;
        reset = 1'b1;

        // Overflow, reload and interrupt period.
        wr(A_TH, 32'hFFFF_FFF0);
        wr(A_TL, 32'hFFFF_FFFE);
        wr(A_TCON, 3);
        checkVal(32'(IRQ), 0, "irq_after_enable");
        idle(1);
        checkRead(A_TL, 32'hFFFF_FFFF, "tl_first_inc");
        idle(1);
        checkVal(32'(IRQ), 1, "irq_rise");
        checkRead(A_TL, 32'hFFFF_FFF0, "tl_reload");
        wr(A_TCON, 3);
        checkVal(32'(IRQ), 0, "irq_clear");
        idle(14);
        checkRead(A_TL, 32'hFFFF_FFFF, "tl_before_second");
        checkVal(32'(IRQ), 0, "irq_before_second");
        idle(1);
        checkVal(32'(IRQ), 1, "irq_period");
        wr(A_TCON, 0);
        checkVal(32'(IRQ), 0, "irq_disable_clear");

        // Reload without interrupt enable.
        wr(A_TL, 32'hFFFF_FFFE);
        wr(A_TCON, 1);
        idle(2);
        checkRead(A_TL, 32'hFFFF_FFF0, "tl_reload_noirq");
        checkVal(32'(IRQ), 0, "irq_noirq");
        checkRead(A_TCON, 1, "tcon_noirq");
        wr(A_TCON, 0);

        // Collisions at the overflow edge.
        wr(A_TL, 32'hFFFF_FFFE);
        wr(A_TCON, 3);
        idle(1);
        wr(A_TCON, 3);
        checkRead(A_TCON, 7, "tcon_collision");
        checkVal(32'(IRQ), 1, "irq_collision");
        wr(A_TCON, 0);
        wr(A_TL, 32'hFFFF_FFFE);
        wr(A_TCON, 3);
        idle(1);
        wr(A_TL, 32'h55);
        checkRead(A_TL, 32'h55, "tl_collision");
        checkVal(32'(IRQ), 0, "irq_tl_collision");
        wr(A_TCON, 0);

        // Plain bus behaviour.
        wr(A_LED, 32'hA5);
        checkVal(32'(led), 32'hA5, "led_write");
        switch = 8'h3C;
        checkRead(A_SW, 32'h3C, "switch_read");
        Addr = A_SYS; MemRead = 1'b1;
        #1 s0 = ReadData;
        wr(A_SYS, 32'h1234_5678);
        Addr = A_SYS; MemRead = 1'b1;
        #1 checkVal(ReadData, s0 + 32'd1, "systick_wr_ignored");
        MemRead = 1'b0;
        checkRead(32'h4000_0020, 0, "unmapped_read");
        Addr = A_LED; MemRead = 1'b0;
        #1 checkVal(ReadData, 0, "memread_low");
        Addr = A_LED; MemRead = 1'b1; MemWrite = 1'b1; WriteData = 32'h5A;
        #1 checkVal(ReadData, 32'hA5, "rw_pre_value");
        @(posedge clk); #1;
        MemWrite = 1'b0;
        checkRead(A_LED, 32'h5A, "rw_post_value");
`ifdef TIMER_PRESCALE_EN
        wr(A_PS, 3);
        wr(A_TL, 0);
        wr(A_TCON, 1);
        idle(4);
        checkRead(A_TL, 1, "prescale_first");
        idle(4);
        checkRead(A_TL, 2, "prescale_second");
        wr(A_TCON, 0);
        wr(A_PS, 0);
`else
        checkRead(A_PS, 0, "prescale_unmapped");
`endif

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                #1 reset = 1'b0;
                repeat (2) @(posedge clk);
                #1 reset = 1'b1;
                continue;
            end
            ri = 6'($urandom_range(0, 8));
            if ($urandom_range(0, 19) == 0) Addr = $urandom;
            else Addr = {24'h40_0000, ri, 2'($urandom)};
            case (ri)
                6'd0: WriteData = 32'hFFFF_FFE0 | $urandom_range(0, 31);
                6'd1: WriteData = 32'hFFFF_FFF0 | $urandom_range(0, 15);
                6'd2: WriteData = 32'($urandom_range(0, 7));
                6'd6: WriteData = 32'($urandom_range(0, 3));
                default: WriteData = $urandom;
            endcase
            MemRead  = 1'($urandom);
            MemWrite = ($urandom_range(0, 3) == 0);
            switch   = 8'($urandom);
            @(posedge clk); #1;
        end
        MemRead = 1'b0; MemWrite = 1'b0;
        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
